// File: rtl/frame_transmit_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver.
package frame_transmit_pkg;

    localparam logic [7:0]  CRC_POLY   = 8'h07;
    localparam int unsigned STUFF_RUN  = 5;
    localparam int unsigned FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SIZE,
        ST_DATA,
        ST_CRC,
        ST_STOP
    } state_t;

    // A baudrate of zero is treated as one clock per line bit.
    function automatic logic [7:0] bit_clocks(input logic [7:0] baud);
        return (baud == 8'd0) ? 8'd1 : baud;
    endfunction

endpackage

// File: rtl/frame_transmit_crc.sv
// Bit-serial CRC-8 (MSB first, init 0, no reflection, no final XOR).
module crc8_serial
    import frame_transmit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (enable_i) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (((crc_q[7] ^ bit_i) == 1'b1) ? CRC_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/frame_transmit.sv
// Frame transmitter: byte FIFO, size/data/CRC fields with bit stuffing, per-bit baud timing.
module frame_transmit
    import frame_transmit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] baudrate,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [3:0] framesize,
    input  logic       start,
    output logic       TX,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state_q;
    logic       tx_q, busy_q, done_q, err_q;
    logic [7:0] tick_q;
    logic [2:0] run_q;
    logic       last_q;
    logic [7:0] shreg_q;
    logic [2:0] bits_left_q;
    logic [3:0] bytes_left_q;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [3:0] wr_ptr_q, rd_ptr_q;
    logic [4:0] count_q;

    logic       accept, fifo_wr, boundary, in_field, stuff_now;
    logic       field_next, field_end, load_byte;
    logic       emit_en, emit_bit, crc_en, crc_bit;
    logic [7:0] fifo_rd, crc;

    assign fifo_rd   = mem_q[rd_ptr_q];
    assign din_ready = (state_q == ST_IDLE) && (count_q < 5'(FIFO_DEPTH - 1));
    assign fifo_wr   = din_valid && din_ready;
    assign accept    = (state_q == ST_IDLE) && start && ({1'b0, framesize} <= count_q);
    assign boundary  = (state_q != ST_IDLE) && (tick_q == 8'd0);
    assign in_field  = state_q inside {ST_SIZE, ST_DATA, ST_CRC};

    // The last CRC bit is never followed by a stuff bit, whatever the run length.
    assign stuff_now  = boundary && in_field && (run_q == 3'(STUFF_RUN))
                        && !((state_q == ST_CRC) && (bits_left_q == 3'd0));
    assign field_next = boundary && in_field && !stuff_now && (bits_left_q != 3'd0);
    assign field_end  = boundary && in_field && !stuff_now && (bits_left_q == 3'd0);
    assign load_byte  = field_end && (state_q != ST_CRC) && (bytes_left_q != 4'd0);

    // CRC is fed as each data bit goes onto the line, so it is final before the CRC field.
    assign crc_en  = load_byte || (field_next && (state_q == ST_DATA));
    assign crc_bit = load_byte ? fifo_rd[7] : shreg_q[7];

    always_comb begin
        emit_en  = 1'b0;
        emit_bit = 1'b0;
        if (boundary && (state_q == ST_START)) begin
            emit_en  = 1'b1;
            emit_bit = shreg_q[7];
        end else if (field_next) begin
            emit_en  = 1'b1;
            emit_bit = shreg_q[7];
        end else if (load_byte) begin
            emit_en  = 1'b1;
            emit_bit = fifo_rd[7];
        end else if (field_end && (state_q != ST_CRC)) begin
            emit_en  = 1'b1;
            emit_bit = crc[7];
        end
    end

    crc8_serial u_crc (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (crc_en),
        .bit_i    (crc_bit),
        .crc_o    (crc)
    );

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tick_q       <= '0;
            run_q        <= '0;
            last_q       <= 1'b0;
            shreg_q      <= '0;
            bits_left_q  <= '0;
            bytes_left_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Bit length is sampled at every bit start, so baud changes apply at the next bit.
            if (accept || boundary) begin
                tick_q <= bit_clocks(baudrate) - 8'd1;
            end else if (tick_q != 8'd0) begin
                tick_q <= tick_q - 8'd1;
            end
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 4'd1;
                count_q  <= count_q + 5'd1;
            end
            if (load_byte) begin
                rd_ptr_q     <= rd_ptr_q + 4'd1;
                count_q      <= count_q - 5'd1;
                bytes_left_q <= bytes_left_q - 4'd1;
            end
            if (emit_en) begin
                tx_q   <= emit_bit;
                last_q <= emit_bit;
                run_q  <= ((run_q != 3'd0) && (emit_bit == last_q)) ? run_q + 3'd1 : 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_START;
                        tx_q         <= 1'b1;
                        busy_q       <= 1'b1;
                        shreg_q      <= {framesize, 4'h0};
                        bytes_left_q <= framesize;
                        run_q        <= '0;
                        last_q       <= 1'b0;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (boundary) begin
                        state_q     <= ST_SIZE;
                        shreg_q     <= {shreg_q[6:0], 1'b0};
                        bits_left_q <= 3'd3;
                    end
                end
                ST_SIZE, ST_DATA, ST_CRC: begin
                    if (stuff_now) begin
                        tx_q   <= ~last_q;
                        last_q <= ~last_q;
                        run_q  <= 3'd1;
                    end else if (field_next) begin
                        shreg_q     <= {shreg_q[6:0], 1'b0};
                        bits_left_q <= bits_left_q - 3'd1;
                    end else if (load_byte) begin
                        state_q     <= ST_DATA;
                        shreg_q     <= {fifo_rd[6:0], 1'b0};
                        bits_left_q <= 3'd7;
                    end else if (field_end && (state_q != ST_CRC)) begin
                        state_q     <= ST_CRC;
                        shreg_q     <= {crc[6:0], 1'b0};
                        bits_left_q <= 3'd7;
                    end else if (field_end) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (boundary) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TX   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_frame_transmit.sv
// Scoreboard bench for frame_transmit: stimulus pushes expected line waveforms, a monitor compares.
module tb_frame_transmit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] baudrate = 8'd1;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [3:0] framesize = 4'd0;
    logic       start = 1'b0;
    logic       TX, busy, done, err;

    int checks = 0;
    int errors = 0;
    bit exp_tx_q[$];
    int exp_len_q[$];
    logic [7:0] model_fifo[$];
    int frames_pushed = 0;
    int frames_done = 0;
    bit mon_en = 1'b1;

    frame_transmit dut (
        .clk       (clk),
        .reset     (reset),
        .baudrate  (baudrate),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .framesize (framesize),
        .start     (start),
        .TX        (TX),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int crc8_byte(input int c, input int d);
        int r;
        r = (c ^ d) & 255;
        for (int i = 0; i < 8; i++) begin
            r = ((r & 128) != 0) ? (((r << 1) ^ 7) & 255) : ((r << 1) & 255);
        end
        return r;
    endfunction

    // Builds the whole line waveform for one frame from the frame rules, one entry per clock.
    function automatic void push_frame(input int fs, input int b);
        bit fld[$];
        bit line[$];
        int crc, run, eff, d;
        bit last, x;
        crc = 0;
        for (int i = 3; i >= 0; i--) fld.push_back(((fs >> i) & 1) == 1);
        for (int k = 0; k < fs; k++) begin
            d = int'(model_fifo.pop_front());
            for (int i = 7; i >= 0; i--) fld.push_back(((d >> i) & 1) == 1);
            crc = crc8_byte(crc, d);
        end
        for (int i = 7; i >= 0; i--) fld.push_back(((crc >> i) & 1) == 1);
        line.push_back(1'b1);
        run = 0;
        last = 1'b0;
        for (int j = 0; j < fld.size(); j++) begin
            x = fld[j];
            line.push_back(x);
            if (run > 0 && x == last) run++;
            else run = 1;
            last = x;
            if (run == 5 && j != fld.size() - 1) begin
                line.push_back(!x);
                last = !x;
                run = 1;
            end
        end
        line.push_back(1'b0);
        eff = (b == 0) ? 1 : b;
        foreach (line[i]) for (int r = 0; r < eff; r++) exp_tx_q.push_back(line[i]);
        exp_len_q.push_back(line.size() * eff);
        frames_pushed++;
    endfunction

    initial begin : monitor
        int len, bad, first_bad;
        bit e;
        forever begin
            @(negedge clk);
            if (mon_en && busy === 1'b1) begin
                if (exp_len_q.size() == 0) begin
                    check("unexpected_frame_busy", int'(busy), 0);
                    for (int k = 0; k < 20000 && busy === 1'b1; k++) @(negedge clk);
                end else begin
                    len = exp_len_q.pop_front();
                    bad = 0;
                    first_bad = -1;
                    for (int i = 0; i < len; i++) begin
                        if (i > 0) @(negedge clk);
                        e = exp_tx_q.pop_front();
                        if (TX !== e || busy !== 1'b1) begin
                            bad++;
                            if (first_bad < 0) first_bad = i;
                        end
                    end
                    check("frame_wave_bad_cycles", bad, 0);
                    if (bad != 0) $display("  frame %0d first divergence at cycle %0d", frames_done, first_bad);
                    @(negedge clk);
                    check("done_pulse", int'(done), 1);
                    check("busy_low_at_done", int'(busy), 0);
                    frames_done++;
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((frames_done != frames_pushed || busy !== 1'b0) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: frames_done=%0d, expected %0d", frames_done, frames_pushed);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = model_fifo.size() < 15;
        check("din_ready", int'(din_ready), int'(exp_rdy));
        din = d;
        din_valid = 1'b1;
        if (exp_rdy) model_fifo.push_back(d);
    endtask

    task automatic end_writes();
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic do_start(input int fs, input int b, input bit at_done);
        bit acc;
        int k;
        if (at_done) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (done !== 1'b1 && k < 20000);
            check("done_seen_for_b2b", int'(done), 1);
        end else begin
            @(negedge clk);
        end
        acc = (fs <= model_fifo.size());
        baudrate = 8'(b);
        framesize = 4'(fs);
        start = 1'b1;
        if (acc) push_frame(fs, b);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", int'(err), int'(!acc));
        if (!acc) begin
            check("tx_after_reject", int'(TX), 0);
            check("busy_after_reject", int'(busy), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_fifo.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n, fs, b, hi, dcount;
        do_reset();
        check("reset_tx", int'(TX), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_din_ready", int'(din_ready), 1);

        // 0xA5 at baud 4, plus a start while busy that must be ignored
        write_byte(8'hA5);
        end_writes();
        do_start(1, 4, 1'b0);
        repeat (5) @(negedge clk);
        framesize = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_start_while_busy", int'(err), 0);
        wait_idle();

        // 0xFF: run crosses size/data boundary
        write_byte(8'hFF);
        end_writes();
        do_start(1, 2, 1'b0);
        wait_idle();

        // Reject when framesize exceeds stored bytes, then drain and send empty frame
        write_byte(8'h12);
        write_byte(8'h34);
        end_writes();
        do_start(3, 4, 1'b0);
        do_start(2, 3, 1'b0);
        wait_idle();
        do_start(0, 2, 1'b0);
        wait_idle();

        // Back-to-back: second start lands in the done cycle
        write_byte(8'h00);
        write_byte(8'h3C);
        write_byte(8'hF0);
        end_writes();
        do_start(1, 2, 1'b0);
        do_start(2, 1, 1'b1);
        wait_idle();

        // Reset during a DATA bit aborts the frame
        mon_en = 1'b0;
        write_byte(8'hC3);
        write_byte(8'h5A);
        end_writes();
        do_start(2, 2, 1'b0);
        exp_len_q.delete();
        exp_tx_q.delete();
        frames_pushed = frames_done;
        repeat (14) @(negedge clk);
        do_reset();
        check("abort_tx", int'(TX), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_din_ready", int'(din_ready), 1);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", dcount, 0);
        mon_en = 1'b1;

        // Fill to 15, a 16th write is dropped; send all 15 at baud 0
        for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 255)));
        end_writes();
        check("din_ready_full", int'(din_ready), 0);
        do_start(15, 0, 1'b0);
        wait_idle();
        do_start(1, 1, 1'b0);

        // Random frames
        for (int it = 0; it < 14; it++) begin
            wait_idle();
            n = $urandom_range(0, 15 - model_fifo.size());
            for (int i = 0; i < n; i++) write_byte(8'($urandom_range(0, 255)));
            end_writes();
            hi = model_fifo.size() + 2;
            if (hi > 15) hi = 15;
            fs = $urandom_range(0, hi);
            b = $urandom_range(0, 3);
            do_start(fs, b, 1'b0);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_transmit.md
FRAME_TRANSMIT -- requirements
Module: frame_transmit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: baudrate  input  8  clocks per line bit; value 0 SHALL be treated as 1.
REQ-005 Port: din  input  8  byte to be loaded into the frame buffer.
REQ-006 Port: din_valid  input  1  din is written this cycle if din_ready=1.
REQ-007 Port: din_ready  output  1  high when idle and the buffer holds fewer than 15 bytes.
REQ-008 Port: framesize  input  4  number of data bytes to send (0..15), sampled on an accepted start.
REQ-009 Port: start  input  1  request to transmit one frame.
REQ-010 Port: TX  output  1  serial line; idle level 0.
REQ-011 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-012 Port: done  output  1  one-cycle pulse in the cycle after the stop bit period ends.
REQ-013 Port: err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 Frame order: start bit (1), framesize[3:0] MSB first, framesize data bytes MSB first in load order, CRC byte MSB first, stop bit (0).
REQ-015 Each line bit, stuff bits included, SHALL be driven for exactly max(baudrate,1) clocks.
REQ-016 Bytes SHALL be written into a 16x8 FIFO when din_valid and din_ready are both high; no write SHALL occur while busy.
REQ-017 start SHALL be accepted only when idle and framesize <= stored byte count; otherwise err SHALL pulse and no state SHALL change.
REQ-018 start while busy SHALL be ignored without err.
REQ-019 TX SHALL go high in the cycle after an accepted start.
REQ-020 States: IDLE -> START -> SIZE (4 bits) -> DATA (8*framesize bits; skipped if 0) -> CRC (8 bits) -> STOP -> IDLE.
REQ-021 CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over data bytes only; framesize 0 SHALL give CRC 0x00.
REQ-022 Bit stuffing SHALL apply to SIZE, DATA and CRC bits: after 5 consecutive identical transmitted bits, one complement bit is inserted; the run counter SHALL span field boundaries and count stuff bits; it SHALL reset at the START bit.
REQ-023 Stuff bits SHALL NOT enter the CRC and SHALL NOT be inserted after the last CRC bit before STOP.
REQ-024 Bytes sent SHALL be removed from the FIFO; bytes beyond framesize SHALL remain for the next frame.
REQ-025 done and busy=0 SHALL coincide; a new start is accepted in the done cycle.
REQ-026 A baudrate change mid-frame SHALL take effect at the next bit boundary.

Reset
REQ-027 On reset, in the next cycle: TX=0, busy=0, done=0, err=0, FIFO empty, din_ready=1, state IDLE, counters and CRC cleared.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with no stop bit and no done.

Structure
REQ-029 A shared package SHALL hold the state enum, CRC_POLY=8'h07, STUFF_RUN=5, and FIFO_DEPTH=16.
REQ-030 CRC SHALL be a sub-module crc8_serial (enable, clear, bit in, 8-bit out) reusable by the receiver.

Verification
REQ-031 Load 0xA5, framesize=1, baudrate=4, start: TX=1,0001,10100101,01110010(CRC 0x72),0; 22 bits, 88 clocks; then done pulses.
REQ-032 Load 0xFF, framesize=1: TX shows a stuffed 0 after the 4th data bit (run begins at the last size bit); CRC 0xF3 follows with stuffing rules applied.
REQ-033 Load two bytes, start with framesize=3: err pulses, TX stays 0, FIFO count stays 2.
REQ-034 Start with framesize=0 and FIFO empty: size 0000, a stuffed 1 after the first CRC zero, CRC 0x00 completes, then stop bit 0.
REQ-035 Reset asserted during a DATA bit: next cycle TX=0, busy=0, din_ready=1; no done pulse.
REQ-036 Write 15 bytes: din_ready drops after the 15th; a 16th din_valid is not stored; baudrate=0 gives 1-clock bits.
